// File: rtl/instruction_packer_pkg.sv
// Shared definitions for the RV32IM instruction packer.
// Holds the format-select codes, the base opcodes, the controller state encoding and a helper
// that tests whether a 32-bit value fits a narrower two's-complement field.
package instruction_packer_pkg;

  // Format-select codes carried on selection_i; 6 and 7 are invalid.
  localparam logic [2:0] SEL_R  = 3'd0;
  localparam logic [2:0] SEL_I  = 3'd1;
  localparam logic [2:0] SEL_U  = 3'd2;
  localparam logic [2:0] SEL_S  = 3'd3;
  localparam logic [2:0] SEL_B  = 3'd4;
  localparam logic [2:0] SEL_UJ = 3'd5;

  // RV32I/M base opcodes.
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;

  typedef enum logic [1:0] {StIdle, StRun, StFull} state_e;

  // True when value[31:msb] are all equal, i.e. value fits an (msb+1)-bit signed field.
  function automatic logic fits_signed(logic [31:0] value, int unsigned msb);
    logic [31:0] upper;
    upper = $signed(value) >>> msb;
    return (upper == '0) || (upper == '1);
  endfunction

endpackage

// File: rtl/instruction_packer_if.sv
// Descriptor handshake and instruction-memory write bus of the instruction packer.
//   valid_i/ready_o      descriptor handshake
//   selection_i..imm_i   instruction fields
//   mem_we_o/addr/data   instruction-memory write port
// master: program loader side; slave: the packer.
interface instruction_packer_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              valid_i;
  logic              ready_o;
  logic [2:0]        selection_i;
  logic [6:0]        opcode_i;
  logic [4:0]        rd_i;
  logic [4:0]        rs1_i;
  logic [4:0]        rs2_i;
  logic [2:0]        funct3_i;
  logic [6:0]        funct7_i;
  logic [31:0]       imm_i;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_data_o;

  modport master (
    output valid_i, selection_i, opcode_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i,
    input  ready_o, mem_we_o, mem_addr_o, mem_data_o
  );

  modport slave (
    input  valid_i, selection_i, opcode_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i,
    output ready_o, mem_we_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/instruction_packer_imm_inserter.sv
// imm_inserter: combinational packing of instruction fields and immediate into a 32-bit word.
//   sel, opcode, rd, rs1, rs2, funct3, funct7, imm   field inputs
//   word                                           packed instruction
//   range_ok                                       immediate/format acceptable
// With INSTR_PACKER_RANGE_CHECK_EN defined, range_ok flags out-of-range immediates and invalid
// selections; otherwise it is tied high and immediates are silently truncated.
module imm_inserter
  import instruction_packer_pkg::*;
(
  input  logic [2:0]  sel,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        range_ok
);

  always_comb begin
    // Invalid selections fall through to the R layout.
    word = {funct7, rs2, rs1, funct3, rd, opcode};
    case (sel)
      SEL_I:  word = {imm[11:0], rs1, funct3, rd, opcode};
      SEL_U:  word = {imm[31:12], rd, opcode};
      SEL_S:  word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      SEL_B:  word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      SEL_UJ: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: ;
    endcase
  end

`ifdef INSTR_PACKER_RANGE_CHECK_EN
  always_comb begin
    range_ok = 1'b0;
    case (sel)
      SEL_R:        range_ok = 1'b1;
      SEL_I, SEL_S: range_ok = fits_signed(imm, 11);
      SEL_U:        range_ok = (imm[11:0] == 12'd0);
      // Upper bound is odd, so the even test also trims 4095 / 2**20-1.
      SEL_B:        range_ok = fits_signed(imm, 12) && !imm[0];
      SEL_UJ:       range_ok = fits_signed(imm, 20) && !imm[0];
      default:      range_ok = 1'b0;
    endcase
  end
`else
  assign range_ok = 1'b1;
`endif

endmodule

// File: rtl/instruction_packer.sv
// instruction_packer: sequential RV32IM instruction encoder.
// Accepts field-level descriptors over bus (slave modport), packs them and writes each word to
// instruction memory at an auto-incrementing word address.
//   clk_i, rst_i   clock, asynchronous active-high reset
//   start_i        begin a session (clears address, count, error)
//   finish_i       end the session
//   count_o        words written this session
//   full_o         memory full
//   err_o          sticky range/format error
//   bus            descriptor handshake + memory write port
// Optional feature: INSTR_PACKER_RANGE_CHECK_EN enables immediate/format rejection.
module instruction_packer
  import instruction_packer_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              finish_i,
  output logic [ADDR_W:0]   count_o,
  output logic              full_o,
  output logic              err_o,
  instruction_packer_if.slave bus
);

  // Count value at which the next accepted word is the last one that fits.
  localparam logic [ADDR_W:0] LastCount = {1'b0, {ADDR_W{1'b1}}};

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] next_q, next_d;
  logic [31:0]       data_q, data_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;
  logic [31:0]       packed_word;
  logic              range_ok;
  logic              ready;
  logic              accept;

  imm_inserter u_imm_inserter (
    .sel      (bus.selection_i),
    .opcode   (bus.opcode_i),
    .rd       (bus.rd_i),
    .rs1      (bus.rs1_i),
    .rs2      (bus.rs2_i),
    .funct3   (bus.funct3_i),
    .funct7   (bus.funct7_i),
    .imm      (bus.imm_i),
    .word     (packed_word),
    .range_ok (range_ok)
  );

  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    next_d  = next_q;
    data_d  = data_q;
    count_d = count_q;
    err_d   = err_q;
    ready   = (state_q == StRun);
    accept  = ready && bus.valid_i;

    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StRun;
          next_d  = '0;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      StRun: begin
        if (accept) begin
          if (range_ok) begin
            we_d    = 1'b1;
            addr_d  = next_q;
            next_d  = next_q + 1'b1;
            data_d  = packed_word;
            count_d = count_q + 1'b1;
            if (count_q == LastCount) state_d = StFull;
          end else begin
            // Rejected descriptors are consumed without a write.
            err_d = 1'b1;
          end
        end
        // A word accepted alongside finish_i is still written next cycle.
        if (finish_i) state_d = StIdle;
      end
      StFull: begin
        if (start_i) begin
          state_d = StRun;
          next_d  = '0;
          count_d = '0;
          err_d   = 1'b0;
        end else if (finish_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      addr_q  <= '0;
      next_q  <= '0;
      data_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      next_q  <= next_d;
      data_q  <= data_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign bus.ready_o    = ready;
  assign bus.mem_we_o   = we_q;
  assign bus.mem_addr_o = addr_q;
  assign bus.mem_data_o = data_q;
  assign count_o        = count_q;
  assign full_o         = (state_q == StFull);
  assign err_o          = err_q;

endmodule
